// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Widest request vector the ID helper accepts; narrower vectors are zero-extended.
  localparam int unsigned MAX_REQ = 32;

  // One-hot bit i maps to ID i+1; an all-zero or multi-hot vector maps to 0.
  function automatic int unsigned onehot_to_id(input logic [MAX_REQ-1:0] vec);
    int unsigned id;
    int unsigned hits;
    id   = 0;
    hits = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (vec[i]) begin
        id   = i + 1;
        hits = hits + 1;
      end
    end
    return (hits == 1) ? id : 0;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N     = 15,
  parameter int unsigned PTR_W = 4
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic             valid
);

  logic [N-1:0] rot;
  logic [N-1:0] low;

  // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    low   = rot & (~rot + 1'b1);
    pick  = N'(({low, low} << ptr) >> N);
    valid = |req;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, encoded ID and optional tenure limit.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 15,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned MAX_HOLD = 0,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [N-1:0]    Req,
  input  logic            Done,
  output logic [N-1:0]    Grant,
  output logic [ID_W-1:0] Grant_Id,
  output logic            Busy,
  output logic            Timeout
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  state_t              state, state_n;
  logic [PTR_W-1:0]    ptr, ptr_n;
  logic [PTR_W-1:0]    owner, owner_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
  logic [N-1:0]        grant_n;
  logic [ID_W-1:0]     grant_id_n;
  logic                busy_n;
  logic                timeout_n;

  logic [N-1:0]        pick;
  logic                pick_valid;
  logic [ID_W-1:0]     pick_id;
  logic                rel_normal;
  logic                rel_limit;

  rr_pick #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (Req),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Encoded ID of the current pick; the owner index is that ID minus one.
  always_comb begin
    pick_id = ID_W'(onehot_to_id(MAX_REQ'(pick)));
  end

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    owner_n    = owner;
    hold_cnt_n = hold_cnt;
    grant_n    = Grant;
    grant_id_n = Grant_Id;
    busy_n     = Busy;
    timeout_n  = 1'b0;
    rel_normal = Done || !Req[owner];
    rel_limit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD));

    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n    = GRANT;
          owner_n    = PTR_W'(pick_id - 1'b1);
          grant_n    = pick;
          grant_id_n = pick_id;
          busy_n     = 1'b1;
          hold_cnt_n = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (rel_normal || rel_limit) begin
          state_n    = IDLE;
          grant_n    = '0;
          grant_id_n = '0;
          busy_n     = 1'b0;
          hold_cnt_n = '0;
          ptr_n      = (owner == PTR_W'(N - 1)) ? '0 : owner + 1'b1;
          timeout_n  = rel_limit && !rel_normal;
        end else if (hold_cnt != '1) begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      Grant    <= '0;
      Grant_Id <= '0;
      Busy     <= 1'b0;
      Timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      hold_cnt <= hold_cnt_n;
      Grant    <= grant_n;
      Grant_Id <= grant_id_n;
      Busy     <= busy_n;
      Timeout  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: one instance without tenure limit, one with MAX_HOLD=4.
module tb_rr_arbiter;

  localparam int NREQ = 15;

  logic            Clk;
  logic            Rst;
  logic [14:0]     Req;
  logic            Done;
  logic [14:0]     grant_o [2];
  logic [3:0]      id_o    [2];
  logic            busy_o  [2];
  logic            to_o    [2];

  int tests;
  int fails;
  int cyc;

  rr_arbiter #(.N(15), .ID_W(4), .MAX_HOLD(0), .HOLD_W(8)) dut0 (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Done(Done),
    .Grant(grant_o[0]), .Grant_Id(id_o[0]), .Busy(busy_o[0]), .Timeout(to_o[0])
  );

  rr_arbiter #(.N(15), .ID_W(4), .MAX_HOLD(4), .HOLD_W(8)) dut4 (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Done(Done),
    .Grant(grant_o[1]), .Grant_Id(id_o[1]), .Busy(busy_o[1]), .Timeout(to_o[1])
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference model: owner as an integer, rotation via modular scan.
  int m_owner [2];
  int m_ptr   [2];
  int m_hold  [2];
  bit m_busy  [2];
  bit m_to    [2];
  int mh      [2];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    bit normal;
    bit lim;
    if (Rst) begin
      m_busy[i] = 0; m_owner[i] = 0; m_ptr[i] = 0; m_hold[i] = 0; m_to[i] = 0;
    end else if (!m_busy[i]) begin
      m_to[i] = 0;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr[i] + k) % NREQ;
        if (Req[c]) begin
          m_owner[i] = c;
          m_busy[i]  = 1;
          m_hold[i]  = 1;
          break;
        end
      end
    end else begin
      normal = Done || !Req[m_owner[i]];
      lim    = (mh[i] != 0) && (m_hold[i] == mh[i]);
      if (normal || lim) begin
        m_busy[i] = 0;
        m_hold[i] = 0;
        m_ptr[i]  = (m_owner[i] + 1) % NREQ;
        m_to[i]   = lim && !normal;
      end else begin
        m_to[i] = 0;
        if (m_hold[i] < 255) m_hold[i] = m_hold[i] + 1;
      end
    end
  endtask

  // One clock: advance the model with the sampled inputs, then compare after the edge.
  task automatic tick();
    int unsigned eg;
    @(posedge Clk);
    model_step(0);
    model_step(1);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      eg = m_busy[i] ? (32'd1 << m_owner[i]) : 0;
      check($sformatf("cyc%0d dut%0d model grant", cyc, i), grant_o[i], eg);
      check($sformatf("cyc%0d dut%0d model id", cyc, i), id_o[i], m_busy[i] ? m_owner[i] + 1 : 0);
      check($sformatf("cyc%0d dut%0d model busy", cyc, i), busy_o[i], m_busy[i]);
      check($sformatf("cyc%0d dut%0d model timeout", cyc, i), to_o[i], m_to[i]);
    end
  endtask

  // Constant expectation for one instance, with Grant and Busy implied by the ID.
  task automatic expect_id(input string tag, input int i, input int unsigned id, input bit to);
    check({tag, " id"}, id_o[i], id);
    check({tag, " busy"}, busy_o[i], (id != 0) ? 1 : 0);
    check({tag, " grant"}, grant_o[i], (id != 0) ? (32'd1 << (id - 1)) : 0);
    check({tag, " timeout"}, to_o[i], to);
  endtask

  typedef struct {
    bit          rst;
    logic [14:0] req;
    bit          done;
    int unsigned id0;
    int unsigned id4;
    bit          to4;
  } vec_t;

  vec_t tbl [32];

  initial begin
    tests = 0; fails = 0; cyc = 0;
    mh[0] = 0; mh[1] = 4;
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = 0; m_ptr[i] = 0; m_hold[i] = 0; m_busy[i] = 0; m_to[i] = 0;
    end
    Rst = 1'b1; Req = '0; Done = 1'b0;

    // reset
    tbl[0]  = '{1'b1, 15'h0000, 1'b0,  0,  0, 1'b0};
    // single request, then Done
    tbl[1]  = '{1'b0, 15'h0004, 1'b0,  3,  3, 1'b0};
    tbl[2]  = '{1'b0, 15'h0004, 1'b1,  0,  0, 1'b0};
    tbl[3]  = '{1'b0, 15'h0000, 1'b0,  0,  0, 1'b0};
    // owner 3 granted, reset mid-grant, then requester 0 wins from Ptr=0
    tbl[4]  = '{1'b0, 15'h0008, 1'b0,  4,  4, 1'b0};
    tbl[5]  = '{1'b1, 15'h0008, 1'b0,  0,  0, 1'b0};
    tbl[6]  = '{1'b0, 15'h0009, 1'b0,  1,  1, 1'b0};
    tbl[7]  = '{1'b0, 15'h0009, 1'b1,  0,  0, 1'b0};
    tbl[8]  = '{1'b0, 15'h0009, 1'b0,  4,  4, 1'b0};
    tbl[9]  = '{1'b0, 15'h0009, 1'b1,  0,  0, 1'b0};
    // grant 13 so Ptr=14, then bits 1 and 14: 15 first, then 2
    tbl[10] = '{1'b0, 15'h2000, 1'b0, 14, 14, 1'b0};
    tbl[11] = '{1'b0, 15'h2000, 1'b1,  0,  0, 1'b0};
    tbl[12] = '{1'b0, 15'h4002, 1'b0, 15, 15, 1'b0};
    tbl[13] = '{1'b0, 15'h4002, 1'b1,  0,  0, 1'b0};
    tbl[14] = '{1'b0, 15'h4002, 1'b0,  2,  2, 1'b0};
    tbl[15] = '{1'b0, 15'h4002, 1'b1,  0,  0, 1'b0};
    // owner 7 drops Req while Req[2] high; others ignored during grant
    tbl[16] = '{1'b0, 15'h0080, 1'b0,  8,  8, 1'b0};
    tbl[17] = '{1'b0, 15'h0084, 1'b0,  8,  8, 1'b0};
    tbl[18] = '{1'b0, 15'h0004, 1'b0,  0,  0, 1'b0};
    tbl[19] = '{1'b0, 15'h0004, 1'b0,  3,  3, 1'b0};
    tbl[20] = '{1'b0, 15'h0004, 1'b1,  0,  0, 1'b0};
    // tenure: Req[5] held; dut4 forced off after 4 cycles, then re-granted
    tbl[21] = '{1'b0, 15'h0020, 1'b0,  6,  6, 1'b0};
    tbl[22] = '{1'b0, 15'h0020, 1'b0,  6,  6, 1'b0};
    tbl[23] = '{1'b0, 15'h0020, 1'b0,  6,  6, 1'b0};
    tbl[24] = '{1'b0, 15'h0020, 1'b0,  6,  6, 1'b0};
    tbl[25] = '{1'b0, 15'h0020, 1'b0,  6,  0, 1'b1};
    tbl[26] = '{1'b0, 15'h0020, 1'b0,  6,  6, 1'b0};
    tbl[27] = '{1'b0, 15'h0020, 1'b0,  6,  6, 1'b0};
    tbl[28] = '{1'b0, 15'h0020, 1'b0,  6,  6, 1'b0};
    tbl[29] = '{1'b0, 15'h0020, 1'b0,  6,  6, 1'b0};
    // Done coincides with the limit: normal release, no Timeout
    tbl[30] = '{1'b0, 15'h0020, 1'b1,  0,  0, 1'b0};
    tbl[31] = '{1'b0, 15'h0000, 1'b0,  0,  0, 1'b0};

    for (int r = 0; r < 32; r++) begin
      Rst = tbl[r].rst; Req = tbl[r].req; Done = tbl[r].done;
      tick();
      expect_id($sformatf("row%0d dut0", r), 0, tbl[r].id0, 1'b0);
      expect_id($sformatf("row%0d dut4", r), 1, tbl[r].id4, tbl[r].to4);
    end

    // Fairness: all requesting, Done on every grant cycle -> IDs 1..15, 1
    Rst = 1'b1; Req = 15'h7FFF; Done = 1'b0;
    tick();
    Rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      Done = 1'b0;
      tick();
      expect_id($sformatf("fair%0d grant", k), 0, (k % 15) + 1, 1'b0);
      expect_id($sformatf("fair%0d grant4", k), 1, (k % 15) + 1, 1'b0);
      Done = 1'b1;
      tick();
      expect_id($sformatf("fair%0d gap", k), 0, 0, 1'b0);
    end

    // Randomized traffic against the model; requests tend to persist for a while.
    Done = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      Rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: Req = 15'($urandom) & 15'($urandom);
          1: Req = 15'(32'd1 << $urandom_range(0, 14));
          2: Req = 15'($urandom);
          default: Req = '0;
        endcase
      end
      Done = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter sharing one resource among up to 15 requesters. Produces a registered one-hot grant and its encoded ID: requester i maps to ID i+1, and ID 0 means no grant. An optional tenure limit forcibly reclaims the resource. Sits between requesting agents and the shared datapath, whose select input is driven by Grant_Id.

## Interface
- N, 15: number of requesters; must satisfy N ≤ 2^ID_W − 1.
- ID_W, 4: width of Grant_Id.
- MAX_HOLD, 0: maximum grant tenure in cycles; 0 disables the limit; otherwise ≥ 1.
- HOLD_W, 8: width of the tenure counter; must satisfy MAX_HOLD < 2^HOLD_W.
- Clk  input  1  single clock; all state updates on its rising edge.
- Rst  input  1  synchronous, active-high reset.
- Req  input  N  request per requester; level-sensitive, held high while the resource is wanted.
- Done  input  1  owner releases the resource; sampled only in GRANT.
- Grant  output  N  registered one-hot grant; all-zero when idle.
- Grant_Id  output  ID_W  registered; owner index+1, 0 when idle.
- Busy  output  1  registered; high while in GRANT.
- Timeout  output  1  registered; one-cycle pulse on a forced release.

## Operation
- States: IDLE, GRANT. Internal registers: Ptr (priority pointer, 0..N−1), Owner, Hold_Cnt (HOLD_W bits).
- Reset (any state, including mid-grant): state=IDLE, Grant=0, Grant_Id=0, Busy=0, Timeout=0, Ptr=0, Hold_Cnt=0.
- IDLE:
  - If Req==0, stay in IDLE.
  - Otherwise, pick the first set bit scanning Ptr, Ptr+1, …, N−1, 0, …, Ptr−1.
  - Load Owner; Grant=1<<Owner; Grant_Id=Owner+1; Hold_Cnt=1; go to GRANT.
- GRANT: a release occurs when any of the following holds:
  - Done=1, or
  - Req[Owner]=0, or
  - MAX_HOLD≠0 and Hold_Cnt==MAX_HOLD.
- On release:
  - State=IDLE; Grant=0; Grant_Id=0; Busy=0; Hold_Cnt=0.
  - Ptr=(Owner+1) mod N, wrapping from N−1 to 0.
  - Timeout=1 only if the tenure limit is the sole release cause.
- In GRANT without release: Hold_Cnt increments, saturating at its maximum; all other outputs hold.
- Req bits other than the owner's are ignored during GRANT.
- Req bits at index ≥ N do not exist; Grant_Id never exceeds N.
- Simultaneous Done and tenure limit: this is a normal release, so Timeout=0.
- A lone requester that keeps Req high after release is re-granted. The rotation only demotes it relative to other active requesters.

## Timing
- Arbitration latency: Req sampled in IDLE at edge k → Grant, Grant_Id and Busy valid in cycle k+1.
- Release latency: release condition at edge m → outputs cleared in cycle m+1.
- Minimum gap between successive grants is exactly one idle cycle: the next grant is visible in cycle m+2 at the earliest.
- Grant, Grant_Id and Busy always change on the same edge; they are never inconsistent.
- Timeout is high for exactly the first idle cycle after a forced release.
- With MAX_HOLD=M, an uninterrupted tenure lasts exactly M cycles of Grant high.

## Structure
- Package arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - function onehot_to_id: one-hot index i → i+1, zero or multi-hot → 0. This is the same mapping the datapath select decoding uses.
- One sub-module, rr_pick: combinational rotating-priority picker. Inputs are Req and Ptr; outputs are a one-hot pick and a valid flag. Implement it by rotating Req by Ptr, finding the lowest set bit, and rotating back.
- The FSM, counters and output registers live in rr_arbiter.

## Test plan
- Reset mid-grant: owner 3 granted, assert Rst for one cycle → next cycle Grant=0, Grant_Id=0, Busy=0. After Rst drops with Req[0]=1, the grant goes to requester 0 (Ptr=0).
- Single request: Req=15'h0004 from idle → one cycle later Grant=15'h0004, Grant_Id=3, Busy=1. Done for one cycle → next cycle all zero.
- Fairness: Req=15'h7FFF held, Done pulsed on every grant cycle → Grant_Id sequence 1, 2, …, 15, 1, with one idle cycle between grants.
- Wrap-around: Ptr=14 via a prior grant to 13; Req bits 1 and 14 set → Grant_Id=15 first, then Grant_Id=2.
- Tenure limit, MAX_HOLD=4: Req[5] held, no Done → Grant_Id=6 for exactly 4 cycles, then Timeout=1 for 1 cycle, then re-grant to Grant_Id=6. Repeat with Done asserted on the 4th cycle → Timeout stays 0.
- Request drop: owner 7 deasserts Req[7] while Req[2] is high → one idle cycle, then Grant_Id=3 and Ptr advanced past 7.
